load_store_unit: RTL and testbench

//  Initiator side of the word-addressed data memory: turns core load/store requests into ren/wen/addr/wdata.
//  The memory has a synchronous 1-cycle read and no byte enables, so the block:
//  - merges SB/SH via read-modify-write;
//  - extracts and sign/zero-extends LB/LBU/LH/LHU;
//  - rejects misaligned accesses and illegal funct3 values.
//  It sits between the execute stage and the data memory.

---
 rtl/load_store_unit_if.sv | 32 +++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: core request/response handshake plus the
// word-addressed data memory port. The slave modport is the LSU's view.
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_funct3_i;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;
  logic              mem_ren_o;
  logic              mem_wen_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only synchronous memory: sub-word loads are
// extracted and extended, sub-word stores go through read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR, RESP} state_t;

  state_t            state, state_n;
  logic              op_we;
  logic [2:0]        op_f3;
  logic [1:0]        op_lane;
  logic [15:0]       op_wdata;
  logic              ren_q, ren_n, wen_q, wen_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n, rdata_q, rdata_n;
  logic              rsp_q, rsp_n, err_q, err_n;
  logic              accept, req_err;
  logic [4:0]        byte_sh;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val, merged;
  logic              unused_addr;

  assign accept      = bus.req_valid_i && (state == IDLE);
  assign unused_addr = ^bus.req_addr_i[31:ADDR_W+2];

  // Illegal encodings and misalignment are judged from the live request on accept
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3_i)
      3'd0:    req_err = 1'b0;
      3'd1:    req_err = bus.req_addr_i[0];
      3'd2:    req_err = |bus.req_addr_i[1:0];
      3'd4:    req_err = bus.req_we_i;
      3'd5:    req_err = bus.req_we_i | bus.req_addr_i[0];
      default: req_err = 1'b1;
    endcase
  end

  assign byte_sh = {op_lane, 3'b000};
  assign rd_byte = 8'(bus.mem_rdata_i >> byte_sh);
  assign rd_half = op_lane[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];

  always_comb begin
    load_val = bus.mem_rdata_i;
    case (op_f3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_val = {24'd0, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = bus.mem_rdata_i;
    endcase
  end

  // Only SB and SH reach the merge; every bit outside the lane keeps the read word
  always_comb begin
    if (op_f3 == 3'd0)
      merged = (bus.mem_rdata_i & ~(32'h0000_00FF << byte_sh)) |
               ({24'd0, op_wdata[7:0]} << byte_sh);
    else if (op_lane[1])
      merged = {op_wdata, bus.mem_rdata_i[15:0]};
    else
      merged = {bus.mem_rdata_i[31:16], op_wdata};
  end

  always_comb begin
    state_n = state;
    ren_n   = 1'b0;
    wen_n   = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = 32'd0;
    rsp_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_n = bus.req_addr_i[ADDR_W+1:2];
          if (req_err) begin
            state_n = RESP;
            rsp_n   = 1'b1;
            err_n   = 1'b1;
          end else if (bus.req_we_i && bus.req_funct3_i == 3'd2) begin
            state_n = WR;
            wen_n   = 1'b1;
            wdata_n = bus.req_wdata_i;
          end else begin
            state_n = RD_REQ;
            ren_n   = 1'b1;
          end
        end
      end
      RD_REQ:  state_n = RD_DATA;
      RD_DATA: begin
        if (op_we) begin
          state_n = WR;
          wen_n   = 1'b1;
          wdata_n = merged;
        end else begin
          state_n = RESP;
          rsp_n   = 1'b1;
          rdata_n = load_val;
        end
      end
      WR: begin
        state_n = RESP;
        rsp_n   = 1'b1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from their next-state values so each one lines up with its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rsp_q    <= 1'b0;
      err_q    <= 1'b0;
      op_we    <= 1'b0;
      op_f3    <= 3'd0;
      op_lane  <= 2'd0;
      op_wdata <= 16'd0;
    end else begin
      state   <= state_n;
      ren_q   <= ren_n;
      wen_q   <= wen_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      rdata_q <= rdata_n;
      rsp_q   <= rsp_n;
      err_q   <= err_n;
      if (accept) begin
        op_we    <= bus.req_we_i;
        op_f3    <= bus.req_funct3_i;
        op_lane  <= bus.req_addr_i[1:0];
        op_wdata <= bus.req_wdata_i[15:0];
      end
    end
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = rsp_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.mem_ren_o   = ren_q;
  assign bus.mem_wen_o   = wen_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: requests push expected responses into a
// scoreboard that a negedge monitor drains whenever rsp_valid_o pulses.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    cycle = 0;
  int    tests = 0;
  int    failures = 0;
  int    accepts = 0;
  int    rsp_count = 0;
  int    last_acc = 0;
  exp_t  sb_q[$];
  logic [31:0] mem [256];

  load_store_unit_if #(.ADDR_W(8)) bus ();

  load_store_unit #(.ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Word memory with a one-cycle synchronous read
  always @(posedge clk) begin
    if (bus.mem_wen_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_ren_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor and memory-port exclusivity check
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid_o) begin
      rsp_count++;
      if (sb_q.size() == 0) begin
        check_output("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("rsp_rdata", bus.rsp_rdata_o, e.rdata);
        check_output("rsp_err", {31'd0, bus.rsp_err_o}, {31'd0, e.err});
        check_output("rsp_latency", 32'(cycle - e.acc), 32'(e.lat));
      end
    end
    if (rst_n && (bus.mem_ren_o || bus.mem_wen_o))
      check_output("ren_wen_exclusive", {31'd0, bus.mem_ren_o & bus.mem_wen_o}, 32'd0);
  end

  // Called at a negedge; returns at the negedge of the cycle after accept with valid still high
  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int lat);
    int waited = 0;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    while (!bus.req_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready_o) begin
      check_output("accept_timeout", 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: exp_rdata, err: exp_err, lat: lat, acc: cycle});
    last_acc = cycle;
    accepts++;
    @(negedge clk);
  endtask

  task automatic drain();
    int waited = 0;
    bus.req_valid_i = 1'b0;
    while ((!bus.req_ready_o || sb_q.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_output("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int acc_log[4];
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'd0;
    bus.req_wdata_i  = 32'd0;

    // Reset values
    @(negedge clk);
    check_output("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check_output("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check_output("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    check_output("rst_rsp_err", {31'd0, bus.rsp_err_o}, 32'd0);
    check_output("rst_ren", {31'd0, bus.mem_ren_o}, 32'd0);
    check_output("rst_wen", {31'd0, bus.mem_wen_o}, 32'd0);
    check_output("rst_addr", {24'd0, bus.mem_addr_o}, 32'd0);
    check_output("rst_wdata", bus.mem_wdata_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SW 0x10
    apply_stimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    check_output("sw_wen", {31'd0, bus.mem_wen_o}, 32'd1);
    check_output("sw_ren", {31'd0, bus.mem_ren_o}, 32'd0);
    check_output("sw_addr", {24'd0, bus.mem_addr_o}, 32'd4);
    check_output("sw_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    drain();

    // Loads from word 4 = 0xDEADBEEF
    apply_stimulus(1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 3);
    check_output("lw_ren", {31'd0, bus.mem_ren_o}, 32'd1);
    drain();
    apply_stimulus(1'b0, 3'd0, 32'h11, 32'd0, 32'hFFFFFFBE, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd4, 32'h11, 32'd0, 32'h000000BE, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd5, 32'h12, 32'd0, 32'h0000DEAD, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd4, 32'h10, 32'd0, 32'h000000EF, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd1, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd5, 32'h10, 32'd0, 32'h0000BEEF, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd2, 32'h410, 32'd0, 32'hDEADBEEF, 1'b0, 3); drain();

    // SB 0x13 read-modify-write
    apply_stimulus(1'b1, 3'd0, 32'h13, 32'h00000055, 32'd0, 1'b0, 4);
    check_output("sb_ren_t1", {31'd0, bus.mem_ren_o}, 32'd1);
    @(negedge clk);
    check_output("sb_wen_t2", {31'd0, bus.mem_wen_o}, 32'd0);
    @(negedge clk);
    check_output("sb_wen_t3", {31'd0, bus.mem_wen_o}, 32'd1);
    check_output("sb_wdata", bus.mem_wdata_o, 32'h55ADBEEF);
    check_output("sb_addr", {24'd0, bus.mem_addr_o}, 32'd4);
    drain();
    apply_stimulus(1'b0, 3'd2, 32'h10, 32'd0, 32'h55ADBEEF, 1'b0, 3); drain();

    // SH upper half of word 5
    apply_stimulus(1'b1, 3'd2, 32'h14, 32'h00000000, 32'd0, 1'b0, 2); drain();
    apply_stimulus(1'b1, 3'd1, 32'h16, 32'h9999ABCD, 32'd0, 1'b0, 4); drain();
    apply_stimulus(1'b0, 3'd2, 32'h14, 32'd0, 32'hABCD0000, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd1, 32'h16, 32'd0, 32'hFFFFABCD, 1'b0, 3); drain();

    // Error cases: no memory access, response on the next cycle
    apply_stimulus(1'b0, 3'd2, 32'h12, 32'd0, 32'd0, 1'b1, 1);
    check_output("err_lw_noaccess", {30'd0, bus.mem_ren_o, bus.mem_wen_o}, 32'd0);
    drain();
    apply_stimulus(1'b1, 3'd1, 32'h11, 32'h1234, 32'd0, 1'b1, 1);
    check_output("err_sh_noaccess", {30'd0, bus.mem_ren_o, bus.mem_wen_o}, 32'd0);
    drain();
    apply_stimulus(1'b0, 3'd7, 32'h10, 32'd0, 32'd0, 1'b1, 1);
    check_output("err_f3_noaccess", {30'd0, bus.mem_ren_o, bus.mem_wen_o}, 32'd0);
    drain();
    apply_stimulus(1'b1, 3'd4, 32'h10, 32'h77, 32'd0, 1'b1, 1); drain();
    apply_stimulus(1'b1, 3'd2, 32'h12, 32'h77, 32'd0, 1'b1, 1); drain();
    apply_stimulus(1'b0, 3'd5, 32'h13, 32'd0, 32'd0, 1'b1, 1); drain();

    // Reset during RD_DATA of SB 0x10 aborts the store
    apply_stimulus(1'b1, 3'd0, 32'h10, 32'h000000AA, 32'd0, 1'b0, 4);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    accepts--;
    #1;
    check_output("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check_output("abort_wen", {31'd0, bus.mem_wen_o}, 32'd0);
    check_output("abort_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check_output("post_rst_wen", {31'd0, bus.mem_wen_o}, 32'd0);
    apply_stimulus(1'b0, 3'd2, 32'h10, 32'd0, 32'h55ADBEEF, 1'b0, 3); drain();

    // Back-to-back SWs with valid held high
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 3'd2, 32'h20 + 32'(4 * i), 32'h1000 + 32'(i), 32'd0, 1'b0, 2);
      acc_log[i] = last_acc;
    end
    drain();
    for (int i = 1; i < 4; i++)
      check_output("b2b_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'd3);
    apply_stimulus(1'b0, 3'd2, 32'h2C, 32'd0, 32'h00001003, 1'b0, 3); drain();
    apply_stimulus(1'b0, 3'd2, 32'h20, 32'd0, 32'h00001000, 1'b0, 3); drain();

    check_output("rsp_count", 32'(rsp_count), 32'(accepts));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
